mult_pipe_hs_wrapper: RTL and testbench

- Parametrised successor to the fixed 4-bit registered multiplier test wrapper.
- Multiplies two WIDTH-bit operands with a per-transaction signed/unsigned mode select.
- Carries results through a configurable-depth pipeline with valid/ready handshakes on both sides.
- Per-stage bubble collapsing and backpressure.
- Used as the timing/QoR harness for multiplier variants and as a drop-in datapath block feeding stallable consumers.

---
 rtl/mult_pipe_hs_wrapper.sv | 123 ++++++++++++
 tb/tb_mult_pipe_hs_wrapper.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_hs_wrapper.sv
// mult_pipe_hs_wrapper
//
// Purpose:
//   Pipelined WIDTH x WIDTH multiplier with a per-transaction signed/unsigned
//   select. Valid/ready handshakes on both sides, per-stage bubble collapse
//   and backpressure. Total depth LAT = STAGES+2 register stages:
//     stage 0          : operand register (multiplicand, multiplier, mode)
//     stage 1          : product computed from stage 0 and registered
//     stages 2..LAT-2  : plain delay registers
//     stage LAT-1      : output register (stage 1 itself when STAGES=0)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   in_valid     in   operand transaction offered
//   in_ready     out  transaction accepted this cycle (never depends on in_valid)
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   multiplicand in   operand A [WIDTH]
//   multiplier   in   operand B [WIDTH]
//   out_valid    out  product available
//   out_ready    in   consumer accepts the product
//   product      out  result [2*WIDTH], stable while stalled
//   busy         out  any stage holds a valid entry
module mult_pipe_hs_wrapper #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int LAT = STAGES + 2;
    localparam int PW  = 2 * WIDTH;

    logic [LAT-1:0]   vld_p;
    logic [LAT-1:0]   en_p;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplier_p0;
    logic             smode_p0;
    logic [PW-1:0]    prod_p [1:LAT-1];

    // Extends both operands to the full product width (sign or zero) and
    // keeps the low PW bits, which is exact for every operand pair,
    // including most-negative * most-negative.
    function automatic logic [PW-1:0] mul_ext(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sm
    );
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = sm ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = sm ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // A stage may load when it is empty or when the stage after it loads.
    // The chain variable walks from the output back to the input so that the
    // enable vector is never read while being built.
    always_comb begin
        logic chain;
        en_p         = '0;
        chain        = !vld_p[LAT-1] || out_ready;
        en_p[LAT-1]  = chain;
        for (int i = LAT - 2; i >= 0; i--) begin
            chain   = !vld_p[i] || chain;
            en_p[i] = chain;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p     <= '0;
            mcand_p0  <= '0;
            mplier_p0 <= '0;
            smode_p0  <= 1'b0;
            for (int i = 1; i < LAT; i++) begin
                prod_p[i] <= '0;
            end
        end else begin
            // ---- stage 0: operand register ----
            if (en_p[0]) begin
                vld_p[0] <= in_valid;
                if (in_valid) begin
                    mcand_p0  <= multiplicand;
                    mplier_p0 <= multiplier;
                    smode_p0  <= signed_mode;
                end
            end
            // ---- stage 1: product register ----
            if (en_p[1]) begin
                vld_p[1] <= vld_p[0];
                if (vld_p[0]) begin
                    prod_p[1] <= mul_ext(mcand_p0, mplier_p0, smode_p0);
                end
            end
            // ---- stages 2..LAT-1: delay chain ending in the output register ----
            for (int i = 2; i < LAT; i++) begin
                if (en_p[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    if (vld_p[i-1]) begin
                        prod_p[i] <= prod_p[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = en_p[0];
    assign out_valid = vld_p[LAT-1];
    assign product   = prod_p[LAT-1];
    assign busy      = |vld_p;

endmodule

// File: tb/tb_mult_pipe_hs_wrapper.sv
module tb_mult_pipe_hs_wrapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A: WIDTH=4, STAGES=1 (LAT=3)
    logic       a_in_valid, a_in_ready, a_sm, a_out_valid, a_out_ready, a_busy;
    logic [3:0] a_mc, a_mp;
    logic [7:0] a_prod;

    // DUT B: WIDTH=8, STAGES=3 (LAT=5)
    logic        b_in_valid, b_in_ready, b_sm, b_out_valid, b_out_ready, b_busy;
    logic [7:0]  b_mc, b_mp;
    logic [15:0] b_prod;

    mult_pipe_hs_wrapper #(.WIDTH(4), .STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .signed_mode(a_sm),
        .multiplicand(a_mc), .multiplier(a_mp),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .product(a_prod), .busy(a_busy)
    );

    mult_pipe_hs_wrapper #(.WIDTH(8), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .signed_mode(b_sm),
        .multiplicand(b_mc), .multiplier(b_mp),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .product(b_prod), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0]  pend_q[$];   // DUT A ops waiting to be offered: {sm, a, b}
    logic [7:0]  exp_q[$];    // DUT A expected products in acceptance order
    logic [15:0] bexp_q[$];   // DUT B expected products

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference product via integer arithmetic on w-bit operands.
    function automatic logic [15:0] ref_mul(input logic sm, input int w,
                                            input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        if (sm && a[w-1]) x = x - (1 << w);
        if (sm && b[w-1]) y = y - (1 << w);
        p = x * y;
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic [8:0] op);
        logic [15:0] r;
        r = ref_mul(op[8], 4, {4'b0, op[7:4]}, {4'b0, op[3:0]});
        return r[7:0];
    endfunction

    // One cycle of DUT A: offer the head of pend_q, score any output transfer.
    task automatic cycle_a(output bit acc);
        a_in_valid = (pend_q.size() > 0);
        if (a_in_valid) {a_sm, a_mc, a_mp} = pend_q[0];
        #1;
        acc = 1'b0;
        if (a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) chk("a_spurious_output", 1, 0);
            else chk("a_order", a_prod, exp_q.pop_front());
        end
        if (a_in_valid && a_in_ready) begin
            exp_q.push_back(ref4(pend_q.pop_front()));
            acc = 1'b1;
        end
        tick;
    endtask

    task automatic run_a(input string tag, input int budget);
        int n;
        bit got;
        n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < budget) begin
            cycle_a(got);
            n++;
        end
        a_in_valid = 1'b0;
        chk(tag, exp_q.size() + pend_q.size(), 0);
    endtask

    task automatic op_a(input string tag, input logic sm, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp);
        int n;
        a_in_valid = 1'b1; a_sm = sm; a_mc = a; a_mp = b;
        #1;
        chk({tag, "_in_ready"}, a_in_ready, 1);
        tick;
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 10) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk(tag, a_prod, exp);
        tick;
    endtask

    initial begin
        bit    got;
        int    acc;
        bit    leaked;
        bit    prev_hold;
        logic [15:0] prev_prod;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_sm = 1'b0; a_mc = '0; a_mp = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_sm = 1'b0; b_mc = '0; b_mp = '0; b_out_ready = 1'b1;
        tick; tick;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_product", a_prod, 8'h00);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", a_in_ready, 1);

        // Most-negative squared, signed: latency and value
        a_in_valid = 1'b1; a_sm = 1'b1; a_mc = 4'b1000; a_mp = 4'b1000;
        tick;
        a_in_valid = 1'b0;
        chk("t1_e0_out_valid", a_out_valid, 0);
        tick;
        chk("t1_e1_out_valid", a_out_valid, 0);
        tick;
        chk("t1_e2_out_valid", a_out_valid, 1);
        chk("t1_product", a_prod, 8'h40);
        tick;
        chk("t1_after_out_valid", a_out_valid, 0);
        chk("t1_after_busy", a_busy, 0);

        // Mode select back-to-back, one result per cycle
        a_in_valid = 1'b1; a_sm = 1'b0; a_mc = 4'hF; a_mp = 4'h1;
        tick;
        a_sm = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        chk("t2_first_valid", a_out_valid, 1);
        chk("t2_first_unsigned", a_prod, 8'h0F);
        tick;
        chk("t2_second_valid", a_out_valid, 1);
        chk("t2_second_signed", a_prod, 8'hFF);
        tick;
        chk("t2_done", a_out_valid, 0);

        // Arithmetic corners
        op_a("u15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
        op_a("s7xm1",  1'b1, 4'h7, 4'hF, 8'hF9);
        op_a("sm8x7",  1'b1, 4'h8, 4'h7, 8'hC8);

        // Backpressure: 5 ops under a stall, exactly LAT accepts
        a_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) pend_q.push_back({1'b0, 4'(i), 4'd3});
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            cycle_a(got);
            acc += int'(got);
        end
        chk("bp_accepts", acc, 3);
        #1;
        chk("bp_in_ready_low", a_in_ready, 0);
        chk("bp_hold_first", a_prod, 8'h03);
        chk("bp_out_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        #1;
        chk("bp_full_release_ready", a_in_ready, 1);
        run_a("bp_drain", 40);

        // Bubble collapse behind a stalled head
        a_out_ready = 1'b0;
        pend_q.push_back({1'b0, 4'd2, 4'd2});
        cycle_a(got);
        chk("bc_first_accept", got, 1);
        a_in_valid = 1'b0;
        tick; tick; tick;
        chk("bc_head_valid", a_out_valid, 1);
        chk("bc_head_value", a_prod, 8'h04);
        pend_q.push_back({1'b0, 4'd3, 4'd3});
        pend_q.push_back({1'b0, 4'd4, 4'd4});
        cycle_a(got);
        chk("bc_second_accept", got, 1);
        cycle_a(got);
        chk("bc_third_accept", got, 1);
        a_in_valid = 1'b1;
        #1;
        chk("bc_full_in_ready", a_in_ready, 0);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        run_a("bc_drain", 20);

        // Reset with two ops in flight
        a_in_valid = 1'b1; a_sm = 1'b0; a_mc = 4'd1; a_mp = 4'd1;
        tick;
        a_mc = 4'd2;
        tick;
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_product", a_prod, 8'h00);
        rst_n = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (a_out_valid) leaked = 1'b1;
        end
        chk("mid_rst_no_leak", leaked, 0);

        // Random sweep on WIDTH=8, STAGES=3 with random backpressure
        prev_hold = 1'b0;
        prev_prod = '0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                b_in_valid  = ($urandom_range(0, 3) != 0);
                b_sm        = ($urandom_range(0, 1) != 0);
                b_mc        = 8'($urandom);
                b_mp        = 8'($urandom);
                b_out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                b_in_valid  = 1'b0;
                b_out_ready = 1'b1;
            end
            #1;
            if (prev_hold) chk("b_hold", {15'b0, b_out_valid, b_prod}, {15'b0, 1'b1, prev_prod});
            if (b_out_valid && b_out_ready) begin
                if (bexp_q.size() == 0) chk("b_spurious_output", 1, 0);
                else chk("b_product", b_prod, bexp_q.pop_front());
            end
            if (b_in_valid && b_in_ready) bexp_q.push_back(ref_mul(b_sm, 8, b_mc, b_mp));
            prev_hold = b_out_valid && !b_out_ready;
            prev_prod = b_prod;
            tick;
        end
        chk("b_drained", bexp_q.size(), 0);
        chk("b_idle", b_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
